barrel_bh: RTL and testbench

- Registered logical barrel shifter: shifts the data word left or right by a 0..WIDTH-1 bit amount, zero-filling vacated positions.
- Used as a datapath utility wherever a single-cycle variable shift with a registered result is needed.
- Combinational log2(WIDTH)-stage shift network feeding one output register.

---
 rtl/barrel_pkg.sv | 6 +
 rtl/barrel_stage.sv | 22 ++
 rtl/barrel_bh.sv | 36 +++
 tb/tb_barrel_bh.sv | 88 ++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared constants for the registered logical barrel shifter.
package barrel_pkg;
  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam logic SHIFT_LEFT  = 1'b1;
  localparam logic SHIFT_RIGHT = 1'b0;
endpackage

// File: rtl/barrel_stage.sv
// One cascaded shift stage: passes data through or shifts it by 2^K with zero fill.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned K     = 0
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  logic             i_lr,
  output logic [WIDTH-1:0] o_data
);
  localparam int unsigned SH = 1 << K;

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      if (i_lr == SHIFT_LEFT) o_data = i_data << SH;
      else                    o_data = i_data >> SH;
    end
  end
endmodule

// File: rtl/barrel_bh.sv
// Registered logical barrel shifter: log2(WIDTH) shift stages feeding one output register.
module barrel_bh
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   n,
  input  logic             Lr,
  output logic [WIDTH-1:0] Out
);
  logic [WIDTH-1:0] w_stage [0:SHW];
  logic [WIDTH-1:0] r_out;

  assign w_stage[0] = In;

  // Stage k consumes bit k of the shift amount.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
      .i_data (w_stage[k]),
      .i_en   (n[k]),
      .i_lr   (Lr),
      .o_data (w_stage[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= w_stage[SHW];
  end

  assign Out = r_out;
endmodule

// File: tb/tb_barrel_bh.sv
// Directed and randomized checks of the registered barrel shifter (WIDTH=8).
module tb_barrel_bh;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] In;
  logic [2:0] n;
  logic       Lr;
  logic [7:0] Out;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  barrel_bh #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .In  (In),
    .n   (n),
    .Lr  (Lr),
    .Out (Out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s, input logic l);
    logic [7:0] t;
    t = l ? (d << s) : (d >> s);
    return t;
  endfunction

  // Apply operands away from the edge, then check one cycle later.
  task automatic step(input string tag, input logic r, input logic [7:0] d,
                      input logic [2:0] s, input logic l, input logic [7:0] exp);
    @(negedge clk);
    rst = r; In = d; n = s; Lr = l;
    @(posedge clk);
    #1;
    vectors++;
    assert (Out === exp) else begin
      miscompares++;
      $error("FAIL %s: Out=%h expected %h", tag, Out, exp);
    end
  endtask

  initial begin
    rst = 1'b1; In = 8'hAA; n = 3'd1; Lr = 1'b1;

    step("reset_edge1", 1'b1, 8'hAA, 3'd1, 1'b1, 8'h00);
    step("reset_edge2", 1'b1, 8'hAA, 3'd1, 1'b1, 8'h00);
    step("reset_release", 1'b0, 8'hAA, 3'd1, 1'b1, 8'h54);

    step("n1_right", 1'b0, 8'hAA, 3'd1, 1'b0, 8'h55);
    step("n1_left",  1'b0, 8'hAA, 3'd1, 1'b1, 8'h54);
    step("n2_left",  1'b0, 8'hAA, 3'd2, 1'b1, 8'hA8);
    step("n2_right", 1'b0, 8'hAA, 3'd2, 1'b0, 8'h2A);
    step("n5_left",  1'b0, 8'hAA, 3'd5, 1'b1, 8'h40);
    step("n5_right", 1'b0, 8'hAA, 3'd5, 1'b0, 8'h05);
    step("n0_left",  1'b0, 8'hAA, 3'd0, 1'b1, 8'hAA);
    step("n0_right", 1'b0, 8'hAA, 3'd0, 1'b0, 8'hAA);
    step("n7_81_left",  1'b0, 8'h81, 3'd7, 1'b1, 8'h80);
    step("n7_81_right", 1'b0, 8'h81, 3'd7, 1'b0, 8'h01);
    step("n7_FF_left",  1'b0, 8'hFF, 3'd7, 1'b1, 8'h80);
    step("n7_FF_right", 1'b0, 8'hFF, 3'd7, 1'b0, 8'h01);
    step("n3_right_mixed", 1'b0, 8'hC3, 3'd3, 1'b0, 8'h18);
    step("n4_left_mixed",  1'b0, 8'hC3, 3'd4, 1'b1, 8'h30);
    step("reset_midrun",   1'b1, 8'hFF, 3'd0, 1'b1, 8'h00);

    for (int i = 0; i < 1000; i++) begin
      logic       r;
      logic [7:0] d;
      logic [2:0] s;
      logic       l;
      r = ($urandom_range(0, 39) == 0);
      d = 8'($urandom);
      s = 3'($urandom);
      l = 1'($urandom);
      step("random", r, d, s, l, r ? 8'h00 : ref_shift(d, s, l));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
